// File: rtl/segre_pkg.sv
// Shared types and helpers for the segre store buffer: memory-op sizes,
// store-buffer entry layout and the byte-lane mask decoder.
package segre_pkg;

  localparam int ADDR_SIZE    = 32;
  localparam int WORD_SIZE    = 32;
  localparam int SB_NUM_ELEMS = 4;
  localparam int SB_BYTES     = WORD_SIZE / 8;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } memop_data_type_e;

  // One buffered store: word address, lane-placed data and the bytes it owns.
  typedef struct packed {
    logic [ADDR_SIZE-3:0] addr;
    logic [WORD_SIZE-1:0] data;
    logic [SB_BYTES-1:0]  be;
    logic                 valid;
  } sb_entry_t;

  // Drain-side view of the buffer, presented to the dcache.
  typedef struct packed {
    logic                 data_valid;
    logic [ADDR_SIZE-1:0] addr;
    logic [WORD_SIZE-1:0] data;
    logic [SB_BYTES-1:0]  drain_be;
  } store_buffer_t;

  // Byte lanes touched by an access of the given size at the given offset.
  function automatic logic [SB_BYTES-1:0] memop_byte_mask(input logic [1:0]       offset,
                                                          input memop_data_type_e size);
    logic [SB_BYTES-1:0] mask;
    case (size)
      BYTE:    mask = 4'b0001 << offset;
      HALF:    mask = 4'b0011 << {offset[1], 1'b0};
      WORD:    mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/segre_sb_lookup.sv
// Youngest-first priority matcher over the store-buffer entries.
// Reports whether a load is fully covered (hit), partially covered
// (trouble) or untouched (miss), and returns the forwarded data.
module segre_sb_lookup
  import segre_pkg::*;
#(
  parameter int NUM_ELEMS = SB_NUM_ELEMS,
  localparam int PTR_W    = $clog2(NUM_ELEMS)
) (
  input  logic                 req_i,
  input  logic [ADDR_SIZE-1:0] addr_i,
  input  memop_data_type_e     type_i,
  input  sb_entry_t            entries_i [NUM_ELEMS],
  input  logic [PTR_W-1:0]     tail_i,
  output logic                 hit_o,
  output logic                 trouble_o,
  output logic                 miss_o,
  output logic [WORD_SIZE-1:0] data_o
);

  logic [SB_BYTES-1:0]  w_mask;
  logic [PTR_W-1:0]     w_idx;
  logic                 w_found;
  logic                 w_overlap;
  logic                 w_covered;
  logic [SB_BYTES-1:0]  w_sel_be;
  logic [WORD_SIZE-1:0] w_sel_data;
  logic [WORD_SIZE-1:0] w_shifted;

  // Walk backwards from the tail so the first match found is the youngest.
  always_comb begin
    // NOTE: every comb output gets a default before any branch; a path that
    // leaves one unassigned would infer a latch.
    w_mask     = memop_byte_mask(addr_i[1:0], type_i);
    w_idx      = '0;
    w_found    = 1'b0;
    w_overlap  = 1'b0;
    w_sel_be   = '0;
    w_sel_data = '0;
    for (int k = 1; k <= NUM_ELEMS; k++) begin
      w_idx = tail_i - PTR_W'(k);
      if (entries_i[w_idx].valid && (entries_i[w_idx].addr == addr_i[ADDR_SIZE-1:2])) begin
        if (!w_found) begin
          w_found    = 1'b1;
          w_sel_be   = entries_i[w_idx].be;
          w_sel_data = entries_i[w_idx].data;
        end
        if ((entries_i[w_idx].be & w_mask) != '0) begin
          w_overlap = 1'b1;
        end
      end
    end
  end

  // Classify the lookup and right-justify the forwarded lanes.
  always_comb begin
    w_covered = w_found && ((w_sel_be & w_mask) == w_mask);
    hit_o     = req_i && w_covered;
    trouble_o = req_i && !w_covered && w_overlap;
    miss_o    = req_i && !w_covered && !w_overlap;
    w_shifted = w_sel_data >> {addr_i[1:0], 3'b000};
    data_o    = '0;
    if (hit_o) begin
      case (type_i)
        BYTE:    data_o = {{(WORD_SIZE-8){1'b0}}, w_shifted[7:0]};
        HALF:    data_o = {{(WORD_SIZE-16){1'b0}}, w_shifted[15:0]};
        default: data_o = w_shifted;
      endcase
    end
  end

endmodule

// File: rtl/segre_store_buffer_nway.sv
// N-entry store buffer between TL and MEM: circular FIFO of byte-masked
// committed stores, optional coalescing into the youngest entry, load
// forwarding and an oldest-first drain into the dcache.
module segre_store_buffer_nway
  import segre_pkg::*;
#(
  parameter int NUM_ELEMS = SB_NUM_ELEMS,
  parameter int ADDR_W    = ADDR_SIZE,
  parameter int DATA_W    = WORD_SIZE,
  parameter bit COALESCE  = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_store_i,
  input  logic                  req_load_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_W-1:0]     data_i,
  input  memop_data_type_e      memop_data_type_i,
  input  logic                  flush_chance_i,
  output logic                  hit_o,
  output logic                  miss_o,
  output logic                  trouble_o,
  output logic [DATA_W-1:0]     data_o,
  output logic                  full_o,
  output logic                  data_valid_o,
  output logic [ADDR_W-1:0]     addr_o,
  output logic [DATA_W-1:0]     drain_data_o,
  output logic [DATA_W/8-1:0]   drain_be_o
);

  localparam int PTR_W = $clog2(NUM_ELEMS);
  localparam int CNT_W = PTR_W + 1;

  sb_entry_t           r_entries [NUM_ELEMS];
  logic [PTR_W-1:0]    r_head;
  logic [PTR_W-1:0]    r_tail;
  logic [CNT_W-1:0]    r_count;
  logic                r_full;

  logic [DATA_W/8-1:0] w_store_be;
  logic [DATA_W-1:0]   w_store_lanes;
  logic [DATA_W-1:0]   w_store_bits;
  logic [DATA_W-1:0]   w_store_data;
  logic [DATA_W-1:0]   w_merge_data;
  logic                w_illegal;
  logic                w_store_ok;
  logic                w_drain;
  logic [PTR_W-1:0]    w_youngest;
  logic                w_coalesce;
  logic                w_alloc;
  logic [CNT_W-1:0]    w_count_nxt;
  store_buffer_t       w_drain_sb;

  // Place store bytes on their lanes and decide coalesce vs allocate.
  always_comb begin
    w_store_be = memop_byte_mask(addr_i[1:0], memop_data_type_i);
    case (memop_data_type_i)
      BYTE: begin
        w_store_lanes = {4{data_i[7:0]}};
        w_illegal     = 1'b0;
      end
      HALF: begin
        w_store_lanes = {2{data_i[15:0]}};
        w_illegal     = addr_i[0];
      end
      WORD: begin
        w_store_lanes = data_i;
        w_illegal     = |addr_i[1:0];
      end
      default: begin
        w_store_lanes = data_i;
        w_illegal     = 1'b1;
      end
    endcase
    for (int b = 0; b < DATA_W/8; b++) begin
      w_store_bits[8*b +: 8] = {8{w_store_be[b]}};
    end
    // Unselected lanes are zeroed so a fresh entry carries no stale bytes.
    w_store_data = w_store_lanes & w_store_bits;

    w_drain    = (r_count != '0) && flush_chance_i;
    w_store_ok = req_store_i && !w_illegal && !r_full;
    w_youngest = r_tail - 1'b1;
    // A youngest entry that is also the draining head cannot absorb the store.
    w_coalesce = COALESCE && w_store_ok && (r_count != '0) &&
                 (r_entries[w_youngest].addr == addr_i[ADDR_W-1:2]) &&
                 !(w_drain && (r_count == CNT_W'(1)));
    w_alloc    = w_store_ok && !w_coalesce;
    w_merge_data = (w_store_data & w_store_bits) |
                   (r_entries[w_youngest].data & ~w_store_bits);
    w_count_nxt  = r_count + CNT_W'(w_alloc) - CNT_W'(w_drain);
  end

  // Pointer, count and entry updates; drain and allocate may share a cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: the entry array is reset along with the pointers; it is only a few
    // words and it keeps lookup and drain outputs free of X after reset.
    if (rst_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      for (int i = 0; i < NUM_ELEMS; i++) begin
        r_entries[i] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every read in
      // this block sees the pre-edge value, whatever the statement order.
      if (w_drain) begin
        r_entries[r_head].valid <= 1'b0;
        r_head                  <= r_head + 1'b1;
      end
      if (w_alloc) begin
        r_entries[r_tail] <= '{addr:  addr_i[ADDR_W-1:2],
                               data:  w_store_data,
                               be:    w_store_be,
                               valid: 1'b1};
        r_tail            <= r_tail + 1'b1;
      end else if (w_coalesce) begin
        r_entries[w_youngest].data <= w_merge_data;
        r_entries[w_youngest].be   <= r_entries[w_youngest].be | w_store_be;
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(NUM_ELEMS));
    end
  end

  // Drain word comes straight from the head entry and reads as zero when empty.
  always_comb begin
    w_drain_sb = '0;
    if (r_count != '0) begin
      w_drain_sb.data_valid = 1'b1;
      w_drain_sb.addr       = {r_entries[r_head].addr, 2'b00};
      w_drain_sb.data       = r_entries[r_head].data;
      w_drain_sb.drain_be   = r_entries[r_head].be;
    end
  end

  assign data_valid_o = w_drain_sb.data_valid;
  assign addr_o       = w_drain_sb.addr;
  assign drain_data_o = w_drain_sb.data;
  assign drain_be_o   = w_drain_sb.drain_be;
  assign full_o       = r_full;

  segre_sb_lookup #(
    .NUM_ELEMS (NUM_ELEMS)
  ) u_lookup (
    .req_i     (req_load_i),
    .addr_i    (addr_i),
    .type_i    (memop_data_type_i),
    .entries_i (r_entries),
    .tail_i    (r_tail),
    .hit_o     (hit_o),
    .trouble_o (trouble_o),
    .miss_o    (miss_o),
    .data_o    (data_o)
  );

  a_store_aligned : assert property (@(posedge clk_i) disable iff (rst_i)
    req_store_i |-> !w_illegal)
    else $error("segre_store_buffer_nway: misaligned or illegal store");

  a_store_not_full : assert property (@(posedge clk_i) disable iff (rst_i)
    req_store_i |-> !r_full)
    else $error("segre_store_buffer_nway: store while full");

endmodule
